// File: rtl/lfsr_digit_gen.sv
// Seedable Fibonacci LFSR driving an NCH-slot digit generator with range
// limiting and optional all-distinct digits; results appear on a valid pulse.
module lfsr_digit_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               NCH       = 4,
    parameter int               DIGIT_MAX = 9,
    parameter bit               UNIQUE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [4*NCH-1:0] digits
);

    localparam int               CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);
    localparam logic [3:0]       DMAX    = 4'(DIGIT_MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

    typedef enum logic {IDLE = 1'b0, GEN = 1'b1} fsm_t;

    // The all-zero state would lock the LFSR, so it is never stored.
    function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return nonzero({v[WIDTH-2:0], ^(v & TAPS)});
    endfunction

    fsm_t             fsm_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [CH_W-1:0]  ch_q;
    logic [3:0]       shadow_q [NCH];
    logic [3:0]       cand;
    logic             accept;
    logic [4*NCH-1:0] digits_nxt;

    assign cand = lfsr_q[3:0];

    always_comb begin
        accept = (cand <= DMAX);
        if (UNIQUE) begin
            for (int i = 0; i < NCH; i++) begin
                if ((CH_W'(i) < ch_q) && (shadow_q[i] == cand)) begin
                    accept = 1'b0;
                end
            end
        end
    end

    // The final slot is taken straight from the candidate so the whole
    // result lands in digits on the accepting edge.
    always_comb begin
        digits_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            digits_nxt[4*i +: 4] = (CH_W'(i) == LAST_CH) ? cand : shadow_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_NZ;
            fsm_q  <= IDLE;
            ch_q   <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            digits <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            lfsr_q <= seed_load ? nonzero(seed) : lfsr_next(lfsr_q);
            valid  <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (req) begin
                        fsm_q <= GEN;
                        ch_q  <= '0;
                        busy  <= 1'b1;
                    end
                end
                GEN: begin
                    // A reload edge discards the candidate; drawing resumes from the new seed.
                    if (!seed_load && accept) begin
                        shadow_q[ch_q] <= cand;
                        if (ch_q == LAST_CH) begin
                            digits <= digits_nxt;
                            valid  <= 1'b1;
                            busy   <= 1'b0;
                            fsm_q  <= IDLE;
                            ch_q   <= '0;
                        end else begin
                            ch_q <= ch_q + CH_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_digit_gen.sv
// Bench for lfsr_digit_gen: a default instance and a UNIQUE instance, checked
// against a draw-by-draw model of the digit generator.
module tb_lfsr_digit_gen;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed;
    logic        req_d, req_u;
    logic        busy_d, busy_u;
    logic        valid_d, valid_u;
    logic [15:0] digits_d, digits_u;
    logic [15:0] model_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_digit_gen dut_d (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .req(req_d), .busy(busy_d), .valid(valid_d), .digits(digits_d)
    );

    lfsr_digit_gen #(.DIGIT_MAX(3), .UNIQUE(1'b1)) dut_u (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .req(req_u), .busy(busy_u), .valid(valid_u), .digits(digits_u)
    );

    function automatic logic [15:0] m_nz(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] t;
        int ones;
        t = TAPS;
        ones = 0;
        for (int b = 0; b < 16; b++) if (t[b] && s[b]) ones++;
        return m_nz((s << 1) | 16'(ones % 2));
    endfunction

    // Edge-by-edge draw model; load_edge (counted from 1 after the req edge)
    // replaces the state and skips the draw on that edge.
    function automatic void model_gen(input logic [15:0] s0, input int dmax, input bit uniq,
                                      input int load_edge, input logic [15:0] load_val,
                                      output logic [15:0] dg, output int lat);
        logic [15:0] s;
        logic [15:0] used;
        int n, c;
        s = s0; used = '0; dg = '0; n = 0; lat = 0;
        for (int e = 1; e <= 1000 && n < 4; e++) begin
            lat = e;
            if (e == load_edge) begin
                s = m_nz(load_val);
            end else begin
                c = int'(s[3:0]);
                if (c <= dmax && !(uniq && used[c])) begin
                    dg[4*n +: 4] = s[3:0];
                    used[c] = 1'b1;
                    n++;
                end
                s = m_step(s);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_state <= SEED;
        else if (seed_load) model_state <= m_nz(seed);
        else model_state <= m_step(model_state);
    end

    task automatic issue_req(input bit u, input bit with_seed, input logic [15:0] sd,
                             input int pulse_at, input int sl_at, input logic [15:0] sl_val,
                             output logic [15:0] st, output bit seen, output int lat,
                             output bit busy_seen);
        int k;
        if (u) req_u = 1'b1; else req_d = 1'b1;
        if (with_seed) begin
            seed_load = 1'b1;
            seed = sd;
        end
        @(negedge clk);
        req_u = 1'b0; req_d = 1'b0; seed_load = 1'b0;
        st = model_state;
        busy_seen = u ? busy_u : busy_d;
        seen = 1'b0; lat = 0; k = 0;
        while (!seen && k < 1000) begin
            @(negedge clk);
            k++;
            req_u = 1'b0; req_d = 1'b0; seed_load = 1'b0;
            if ((u ? valid_u : valid_d) === 1'b1) begin
                seen = 1'b1;
                lat = k;
            end else begin
                if (k == pulse_at) begin
                    if (u) req_u = 1'b1; else req_d = 1'b1;
                end
                if (k == sl_at) begin
                    seed_load = 1'b1;
                    seed = sl_val;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; seed_load = 1'b0; seed = '0; req_d = 1'b0; req_u = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (digits_d !== 16'h0) begin errors++; $display("FAIL reset_digits got=%h want=0000", digits_d); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_d); end
        checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_d); end
        checks++; if (dut_d.lfsr_q !== SEED) begin errors++; $display("FAIL reset_state got=%h want=%h", dut_d.lfsr_q, SEED); end
        @(negedge clk);
        checks++; if (dut_d.lfsr_q !== 16'h59C3) begin errors++; $display("FAIL state_1clk got=%h want=59c3", dut_d.lfsr_q); end
        repeat (65534) @(negedge clk);
        checks++; if (dut_d.lfsr_q !== SEED) begin errors++; $display("FAIL period got=%h want=%h", dut_d.lfsr_q, SEED); end
    endtask

    task automatic test_zero_seed;
        seed_load = 1'b1; seed = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        checks++; if (dut_d.lfsr_q !== 16'h0001) begin errors++; $display("FAIL zero_seed got=%h want=0001", dut_d.lfsr_q); end
        @(negedge clk);
        checks++; if (dut_d.lfsr_q !== 16'h0002) begin errors++; $display("FAIL zero_seed_step got=%h want=0002", dut_d.lfsr_q); end
    endtask

    task automatic test_range;
        logic [15:0] sd, st, want;
        int lat, wlat;
        bit seen, bz, together, ok;
        for (int r = 0; r < 200; r++) begin
            sd = 16'($urandom_range(0, 65535));
            together = (r % 2) == 1;
            if (!together) begin
                seed_load = 1'b1; seed = sd;
                @(negedge clk);
                seed_load = 1'b0;
            end
            issue_req(1'b0, together, sd, 0, 0, 16'h0, st, seen, lat, bz);
            model_gen(st, 9, 1'b0, 0, 16'h0, want, wlat);
            checks++; if (bz !== 1'b1) begin errors++; $display("FAIL range_busy r=%0d got=%b want=1", r, bz); end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL range_timeout r=%0d got=no_valid want=valid", r);
            end else begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (digits_d[4*i +: 4] > 4'd9) ok = 1'b0;
                checks++; if (!ok) begin errors++; $display("FAIL range_nibble r=%0d got=%h want<=9", r, digits_d); end
                checks++; if (lat < 4) begin errors++; $display("FAIL range_minlat r=%0d got=%0d want>=4", r, lat); end
                checks++; if (lat != wlat) begin errors++; $display("FAIL range_lat r=%0d got=%0d want=%0d", r, lat, wlat); end
                checks++; if (digits_d !== want) begin errors++; $display("FAIL range_digits r=%0d got=%h want=%h", r, digits_d, want); end
                checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL range_busy_done r=%0d got=%b want=0", r, busy_d); end
                @(negedge clk);
                checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL range_pulse r=%0d got=%b want=0", r, valid_d); end
            end
        end
    endtask

    task automatic test_unique;
        logic [15:0] sd, st, want, m;
        int lat, wlat;
        bit seen, bz;
        for (int r = 0; r < 100; r++) begin
            sd = 16'($urandom_range(0, 65535));
            seed_load = 1'b1; seed = sd;
            @(negedge clk);
            seed_load = 1'b0;
            issue_req(1'b1, 1'b0, 16'h0, 0, 0, 16'h0, st, seen, lat, bz);
            model_gen(st, 3, 1'b1, 0, 16'h0, want, wlat);
            checks++;
            if (!seen) begin
                errors++; $display("FAIL uniq_timeout r=%0d got=no_valid want=valid", r);
            end else begin
                m = '0;
                for (int i = 0; i < 4; i++) m[digits_u[4*i +: 4]] = 1'b1;
                checks++; if (m !== 16'h000F) begin errors++; $display("FAIL uniq_perm r=%0d got=%h want=perm_0123", r, digits_u); end
                checks++; if (digits_u !== want) begin errors++; $display("FAIL uniq_digits r=%0d got=%h want=%h", r, digits_u, want); end
                checks++; if (lat != wlat) begin errors++; $display("FAIL uniq_lat r=%0d got=%0d want=%0d", r, lat, wlat); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] want;
        int wlat, k;
        bit seen;
        req_d = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            checks++; if (busy_d !== 1'b1 || valid_d !== 1'b0) begin errors++; $display("FAIL b2b_start r=%0d got=busy%b_valid%b want=busy1_valid0", r, busy_d, valid_d); end
            model_gen(model_state, 9, 1'b0, 0, 16'h0, want, wlat);
            seen = 1'b0; k = 0;
            while (!seen && k < 1000) begin
                @(negedge clk);
                k++;
                if (valid_d === 1'b1) seen = 1'b1;
            end
            if (r == 5) req_d = 1'b0;
            checks++; if (!seen || k != wlat) begin errors++; $display("FAIL b2b_lat r=%0d got=%0d want=%0d", r, k, wlat); end
            checks++; if (digits_d !== want) begin errors++; $display("FAIL b2b_digits r=%0d got=%h want=%h", r, digits_d, want); end
        end
        @(negedge clk);
        checks++; if (valid_d !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL b2b_end got=busy%b_valid%b want=busy0_valid0", busy_d, valid_d); end
    endtask

    task automatic test_req_while_busy;
        logic [15:0] st, want;
        int lat, wlat, extra;
        bit seen, bz;
        issue_req(1'b0, 1'b0, 16'h0, 1, 0, 16'h0, st, seen, lat, bz);
        model_gen(st, 9, 1'b0, 0, 16'h0, want, wlat);
        checks++; if (!seen || lat != wlat) begin errors++; $display("FAIL busy_req_lat got=%0d want=%0d", lat, wlat); end
        checks++; if (digits_d !== want) begin errors++; $display("FAIL busy_req_digits got=%h want=%h", digits_d, want); end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_d !== 1'b0 || busy_d !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_req_queued got=%0d want=0", extra); end
    endtask

    task automatic test_seed_mid_gen;
        logic [15:0] st, want, nsd;
        int lat, wlat;
        bit seen, bz;
        for (int r = 0; r < 4; r++) begin
            nsd = 16'($urandom_range(0, 65535));
            issue_req(1'b0, 1'b0, 16'h0, 0, 1, nsd, st, seen, lat, bz);
            model_gen(st, 9, 1'b0, 2, nsd, want, wlat);
            checks++; if (!seen || lat != wlat) begin errors++; $display("FAIL reload_lat r=%0d got=%0d want=%0d", r, lat, wlat); end
            checks++; if (digits_d !== want) begin errors++; $display("FAIL reload_digits r=%0d got=%h want=%h", r, digits_d, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        req_d = 1'b1;
        @(negedge clk);
        req_d = 1'b0;
        @(negedge clk);
        checks++; if (busy_d !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy_d); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy_d); end
        checks++; if (digits_d !== 16'h0) begin errors++; $display("FAIL mid_digits got=%h want=0000", digits_d); end
        checks++; if (dut_d.lfsr_q !== SEED) begin errors++; $display("FAIL mid_state got=%h want=%h", dut_d.lfsr_q, SEED); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_d !== 1'b0 || busy_d !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_valid got=%0d want=0", stray); end
    endtask

    initial begin
        test_reset();
        test_zero_seed();
        test_range();
        test_unique();
        test_back_to_back();
        test_req_while_busy();
        test_seed_mid_gen();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_digit_gen.md
# lfsr_digit_gen

Parametrised pseudo-random digit generator for the alarm subsystem. It replaces the fixed 3-bit per-digit generators with one seedable Fibonacci LFSR of configurable width. On request it fills NCH digit slots with range-limited values, optionally all distinct, and returns them together with a one-cycle valid pulse. The alarm's dismiss-puzzle logic consumes these digits and the display shows them.

## Interface
- WIDTH, 16: LFSR width in bits. Must be at least 5.
- TAPS, 16'hB400: feedback mask. Bit k set means state[k] feeds the XOR. The default is maximal-length (period 65535).
- SEED, 16'hACE1: reset value of the LFSR. A zero value is replaced by 1.
- NCH, 4: number of digit channels. Must be at least 1.
- DIGIT_MAX, 9: largest legal digit, in the range 0..15.
- UNIQUE, 0: when 1, all digits in one result are distinct. Requires NCH <= DIGIT_MAX+1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  load `seed` into the LFSR on the next edge.
- seed  in  WIDTH  new LFSR value.
- req  in  1  start a generation. Sampled only in IDLE.
- busy  out  1  high while in GEN.
- valid  out  1  one-cycle pulse marking a new `digits` value.
- digits  out  4*NCH  channel i occupies digits[4*i+3:4*i].

## Operation
- The LFSR shifts every cycle, including in IDLE and while busy.
  - fb = ^(state & TAPS)
  - next = {state[WIDTH-2:0], fb}
- The all-zero lock-up state is never held. A zero next value (from seed_load or a corrupted state) is written as 1.
- seed_load has priority over the shift. The LFSR takes `seed` (0 becomes 1) instead of shifting.
- The candidate digit is state[3:0], taken from the register value before the edge.
- Reset values:
  - state = SEED (0 becomes 1)
  - digits = 0
  - valid = 0
  - busy = 0
  - FSM in IDLE
  - channel index ch = 0
  - shadow buffer cleared
- FSM states and transitions:
  - IDLE: on req=1, go to GEN with ch=0 and busy=1. Otherwise stay in IDLE.
  - GEN, candidate evaluation on each edge:
    - Accept the candidate if it is <= DIGIT_MAX and, when UNIQUE=1, it differs from every shadow slot 0..ch-1.
    - Accept: write the candidate into shadow slot ch, then increment ch.
    - Reject: leave ch unchanged and retry on the next edge.
  - GEN completion: on the edge that accepts slot NCH-1, the whole shadow buffer is copied into `digits`. On the same edge valid=1, busy=0 and the FSM returns to IDLE.
  - Next edge: valid returns to 0.
- `digits` changes only on completion edges. Partial results are never visible.
- req asserted while busy is ignored and is not queued.
- seed_load during GEN: the LFSR reloads and no candidate is evaluated on that edge. Generation continues from the new state.
- req and seed_load together in IDLE: both take effect. The first candidate comes from the loaded seed on the next edge.
- req on the cycle valid is high (FSM back in IDLE): accepted.
- Asserting rst at any time, including mid-GEN, forces the reset values immediately. No valid is produced for the aborted request.

## Timing
- req sampled high at edge T starts GEN. Candidates are evaluated at edges T+1, T+2, and so on.
- Minimum latency, with no rejections: valid is high for the cycle after edge T+NCH.
- With R rejections, valid is high after edge T+NCH+R. R is unbounded in principle but statistically small: the acceptance rate is (DIGIT_MAX+1)/16 per draw, lower with UNIQUE.
- Back-to-back throughput is one result every NCH+1 cycles at best.
- busy and valid are registered outputs. digits is registered and stable between valid pulses.

## Test plan
- Reset and free-run: defaults, rst pulse.
  - Right after release: digits=0, valid=0, busy=0.
  - After 1 clock: state=16'h59C3.
  - After 65535 clocks: state is back to 16'hACE1.
- Zero seed: seed_load=1 with seed=0 → state=16'h0001 after the edge, then 16'h0002 on the next edge.
- Range limit: DIGIT_MAX=9, NCH=4, 200 requests with random seeds.
  - Every nibble of digits is <= 9.
  - Exactly one valid per request.
  - Latency is >= 4 and equals 4 plus the rejection count computed by a reference model of the LFSR.
- UNIQUE=1, NCH=4, DIGIT_MAX=3 → every result is a permutation of {0,1,2,3}, checked over 100 requests.
- Handshake corners:
  - req held high continuously → new results back-to-back with no dropped or duplicate valid.
  - req pulsed while busy → ignored.
  - seed_load mid-GEN → the digits that follow match a model restarted from the new seed.
- Reset mid-GEN: assert rst two cycles after req → busy=0 immediately, no valid, digits=0, state=SEED.
